// File: rtl/lane_distributor.sv
// lane_distributor: buffers 16-bit beats, stripes them over two byte lanes and frames them into whole symbols.
// Define LANE_DIST_OS_EN to build ordered-set symbol insertion; without it only data and idle are produced.
module lane_distributor #(
    parameter int FIFO_DEPTH = 32
) (
    input  logic                          enc_clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [1:0]                    gen_speed,
    input  logic [15:0]                   in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          os_req,
    input  logic [3:0]                    os_type,
    input  logic [7:0]                    os_byte_0,
    input  logic [7:0]                    os_byte_1,
    output logic                          os_ack,
    output logic [7:0]                    lane_0_tx,
    output logic [7:0]                    lane_1_tx,
    output logic [3:0]                    d_sel,
    output logic                          sym_start,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [3:0]    DSEL_DATA  = 4'd8;
    localparam logic [3:0]    DSEL_IDLE  = 4'd9;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA
`ifdef LANE_DIST_OS_EN
        ,
        ST_OS
`endif
    } state_t;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic [15:0]   rd_word;
    logic          push, pop;

    state_t        state_reg, state_next;
    logic [3:0]    bcnt_reg, bcnt_next;
    logic [3:0]    len_m1_reg, len_m1_next;
    logic [3:0]    len_new_m1;
    logic [LW-1:0] len_new;
    logic          at_boundary;

    logic [7:0]    lane_0_reg, lane_0_next;
    logic [7:0]    lane_1_reg, lane_1_next;
    logic [3:0]    d_sel_reg, d_sel_next;
    logic          sym_start_reg, sym_start_next;

`ifdef LANE_DIST_OS_EN
    logic          os_pending_reg;
    logic [3:0]    os_type_reg;
    logic [7:0]    os_b0_reg, os_b1_reg;
    logic          os_ack_reg, os_ack_next;
    logic          take_os;
`endif

    assign in_ready   = (level_reg != LEVEL_FULL);
    assign push       = in_valid && in_ready;
    assign rd_word    = mem[rd_ptr_reg];
    assign fifo_level = level_reg;
    assign lane_0_tx  = lane_0_reg;
    assign lane_1_tx  = lane_1_reg;
    assign d_sel      = d_sel_reg;
    assign sym_start  = sym_start_reg;

    always_ff @(posedge enc_clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    always_comb begin
        case (gen_speed)
            2'd0:    len_new_m1 = 4'd0;
            2'd1:    len_new_m1 = 4'd15;
            default: len_new_m1 = 4'd7;
        endcase
        len_new     = LW'(len_new_m1) + LW'(1);
        at_boundary = (state_reg == ST_IDLE) || (bcnt_reg == len_m1_reg);

        state_next     = state_reg;
        bcnt_next      = bcnt_reg;
        len_m1_next    = len_m1_reg;
        lane_0_next    = lane_0_reg;
        lane_1_next    = lane_1_reg;
        d_sel_next     = d_sel_reg;
        sym_start_next = 1'b0;
        pop            = 1'b0;
`ifdef LANE_DIST_OS_EN
        os_ack_next    = 1'b0;
        take_os        = 1'b0;
`endif

        if (!enable) begin
            // Abandon any partial symbol; FIFO contents are left untouched.
            state_next  = ST_IDLE;
            bcnt_next   = 4'd0;
            lane_0_next = 8'd0;
            lane_1_next = 8'd0;
            d_sel_next  = DSEL_IDLE;
        end else if (at_boundary) begin
            bcnt_next   = 4'd0;
            len_m1_next = len_new_m1;
`ifdef LANE_DIST_OS_EN
            if (os_pending_reg) begin
                state_next     = ST_OS;
                take_os        = 1'b1;
                os_ack_next    = 1'b1;
                lane_0_next    = os_b0_reg;
                lane_1_next    = os_b1_reg;
                d_sel_next     = os_type_reg;
                sym_start_next = 1'b1;
            end else
`endif
            if (level_reg >= len_new) begin
                state_next     = ST_DATA;
                pop            = 1'b1;
                lane_0_next    = rd_word[7:0];
                lane_1_next    = rd_word[15:8];
                d_sel_next     = DSEL_DATA;
                sym_start_next = 1'b1;
            end else begin
                state_next  = ST_IDLE;
                lane_0_next = 8'd0;
                lane_1_next = 8'd0;
                d_sel_next  = DSEL_IDLE;
            end
        end else begin
            bcnt_next = bcnt_reg + 4'd1;
            // Ordered-set beats repeat the first beat, so only data beats reload the lanes.
            if (state_reg == ST_DATA) begin
                pop         = 1'b1;
                lane_0_next = rd_word[7:0];
                lane_1_next = rd_word[15:8];
                d_sel_next  = DSEL_DATA;
            end
        end
    end

    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            state_reg     <= ST_IDLE;
            bcnt_reg      <= 4'd0;
            len_m1_reg    <= 4'd0;
            lane_0_reg    <= 8'd0;
            lane_1_reg    <= 8'd0;
            d_sel_reg     <= DSEL_IDLE;
            sym_start_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (push && !pop) begin
                level_reg <= level_reg + LW'(1);
            end else if (!push && pop) begin
                level_reg <= level_reg - LW'(1);
            end
            state_reg     <= state_next;
            bcnt_reg      <= bcnt_next;
            len_m1_reg    <= len_m1_next;
            lane_0_reg    <= lane_0_next;
            lane_1_reg    <= lane_1_next;
            d_sel_reg     <= d_sel_next;
            sym_start_reg <= sym_start_next;
        end
    end

`ifdef LANE_DIST_OS_EN
    // A new request wins over the clear from a symbol that is starting on the same edge.
    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            os_pending_reg <= 1'b0;
            os_type_reg    <= 4'd0;
            os_b0_reg      <= 8'd0;
            os_b1_reg      <= 8'd0;
            os_ack_reg     <= 1'b0;
        end else begin
            os_ack_reg <= os_ack_next;
            if (os_req) begin
                os_pending_reg <= 1'b1;
                os_type_reg    <= os_type;
                os_b0_reg      <= os_byte_0;
                os_b1_reg      <= os_byte_1;
            end else if (take_os) begin
                os_pending_reg <= 1'b0;
            end
        end
    end

    assign os_ack = os_ack_reg;
`else
    logic os_unused;
    assign os_unused = ^{os_req, os_type, os_byte_0, os_byte_1};
    assign os_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_lane_distributor.sv
// Randomized and directed bench for lane_distributor, checked every cycle against a queue-based symbol model.
`timescale 1ns/1ps
module tb_lane_distributor;
    localparam int DEPTH = 32;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          enc_clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [1:0]    gen_speed = 2'd2;
    logic [15:0]   in_data = 16'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          os_req = 1'b0;
    logic [3:0]    os_type = 4'd0;
    logic [7:0]    os_byte_0 = 8'd0;
    logic [7:0]    os_byte_1 = 8'd0;
    logic          os_ack;
    logic [7:0]    lane_0_tx, lane_1_tx;
    logic [3:0]    d_sel;
    logic          sym_start;
    logic [LW-1:0] fifo_level;

    always #5 enc_clk = ~enc_clk;

    lane_distributor #(.FIFO_DEPTH(DEPTH)) dut (
        .enc_clk(enc_clk), .rst(rst), .enable(enable), .gen_speed(gen_speed),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .os_req(os_req), .os_type(os_type), .os_byte_0(os_byte_0), .os_byte_1(os_byte_1),
        .os_ack(os_ack), .lane_0_tx(lane_0_tx), .lane_1_tx(lane_1_tx), .d_sel(d_sel),
        .sym_start(sym_start), .fifo_level(fifo_level)
    );

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: beats in a queue, the current symbol as a kind plus beats still to send.
    logic [15:0] q[$];
    int          left = 0;
    int          kind = 0;      // 0 idle, 1 data, 2 ordered set
    bit          pend = 1'b0;
    logic [3:0]  pt = 4'd0;
    logic [7:0]  pb0 = 8'd0, pb1 = 8'd0;
    logic [7:0]  e_l0 = 8'd0, e_l1 = 8'd0;
    logic [3:0]  e_dsel = 4'd9;
    bit          e_ss = 1'b0, e_ack = 1'b0;

    function automatic int sym_len(input logic [1:0] g);
        if (g == 2'd0) return 1;
        if (g == 2'd1) return 16;
        return 8;
    endfunction

    task automatic model_reset();
        q.delete();
        left = 0; kind = 0; pend = 1'b0;
        e_l0 = 8'd0; e_l1 = 8'd0; e_dsel = 4'd9; e_ss = 1'b0; e_ack = 1'b0;
    endtask

    task automatic model_step();
        int          len;
        bit          do_push;
        logic [15:0] beat;
        do_push = in_valid && (q.size() < DEPTH);
        e_ss = 1'b0;
        e_ack = 1'b0;
        if (!enable) begin
            left = 0; kind = 0;
            e_l0 = 8'd0; e_l1 = 8'd0; e_dsel = 4'd9;
        end else if (left == 0) begin
            len = sym_len(gen_speed);
            if (pend) begin
                kind = 2; left = len - 1; pend = 1'b0;
                e_l0 = pb0; e_l1 = pb1; e_dsel = pt; e_ss = 1'b1; e_ack = 1'b1;
            end else if (q.size() >= len) begin
                kind = 1; left = len - 1;
                beat = q.pop_front();
                e_l0 = beat[7:0]; e_l1 = beat[15:8]; e_dsel = 4'd8; e_ss = 1'b1;
            end else begin
                kind = 0;
                e_l0 = 8'd0; e_l1 = 8'd0; e_dsel = 4'd9;
            end
        end else begin
            left--;
            if (kind == 1) begin
                beat = q.pop_front();
                e_l0 = beat[7:0]; e_l1 = beat[15:8];
            end
        end
        if (do_push) q.push_back(in_data);
`ifdef LANE_DIST_OS_EN
        if (os_req) begin
            pend = 1'b1; pt = os_type; pb0 = os_byte_0; pb1 = os_byte_1;
        end
`endif
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge enc_clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge enc_clk);
            if (checking) begin
                chk("lane_0_tx", 32'(lane_0_tx), 32'(e_l0));
                chk("lane_1_tx", 32'(lane_1_tx), 32'(e_l1));
                chk("d_sel", 32'(d_sel), 32'(e_dsel));
                chk("sym_start", 32'(sym_start), 32'(e_ss));
                chk("os_ack", 32'(os_ack), 32'(e_ack));
                chk("fifo_level", 32'(fifo_level), q.size());
                chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
            end
        end
    end

    initial begin
        int          t;
        bit          found;
        logic [15:0] first_beat;

        #1 rst = 1'b0;
        repeat (3) @(negedge enc_clk);
        chk("rst_d_sel", 32'(d_sel), 32'd9);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_sym_start", 32'(sym_start), 32'd0);
        chk("rst_os_ack", 32'(os_ack), 32'd0);
        chk("rst_lane_0", 32'(lane_0_tx), 32'd0);
        checking = 1'b1;
        rst = 1'b1;

        // Gen2 framing with a literal byte pattern and 2-edge latency.
        @(negedge enc_clk);
        enable = 1'b1; gen_speed = 2'd2;
        for (int i = 0; i < 8; i++) begin
            @(negedge enc_clk);
            in_valid = 1'b1; in_data = {8'(i + 1), 8'(i)};
        end
        @(negedge enc_clk);
        in_valid = 1'b0;
        @(posedge enc_clk); #1;
        chk("gen2_first_dsel", 32'(d_sel), 32'd8);
        chk("gen2_first_lane0", 32'(lane_0_tx), 32'd0);
        chk("gen2_first_lane1", 32'(lane_1_tx), 32'd1);
        chk("gen2_first_start", 32'(sym_start), 32'd1);
        for (int i = 1; i < 8; i++) begin
            @(posedge enc_clk); #1;
            chk("gen2_lane0", 32'(lane_0_tx), 32'(i));
            chk("gen2_lane1", 32'(lane_1_tx), 32'(i + 1));
            chk("gen2_start", 32'(sym_start), 32'd0);
        end
        @(posedge enc_clk); #1;
        chk("gen2_after_dsel", 32'(d_sel), 32'd9);

        // Gen3 partial fill stays idle until the 16th beat.
        @(negedge enc_clk);
        gen_speed = 2'd1;
        for (int i = 0; i < 15; i++) begin
            @(negedge enc_clk);
            in_valid = 1'b1; in_data = 16'($urandom);
        end
        @(negedge enc_clk);
        in_valid = 1'b0;
        repeat (3) @(negedge enc_clk);
        chk("gen3_partial_dsel", 32'(d_sel), 32'd9);
        chk("gen3_partial_level", 32'(fifo_level), 32'd15);
        in_valid = 1'b1; in_data = 16'($urandom);
        @(negedge enc_clk);
        in_valid = 1'b0;
        found = 1'b0;
        for (t = 0; t < 10 && !found; t++) begin
            @(posedge enc_clk); #1;
            if (sym_start) found = 1'b1;
        end
        chk("gen3_start_seen", 32'(found), 32'd1);
        chk("gen3_start_wait", 32'(t), 32'd1);
        repeat (15) @(posedge enc_clk);
        #1 chk("gen3_last_dsel", 32'(d_sel), 32'd8);
        @(posedge enc_clk); #1;
        chk("gen3_after_dsel", 32'(d_sel), 32'd9);

        // Ordered-set request during beat 4 of a gen2 data symbol.
        @(negedge enc_clk);
        enable = 1'b0; gen_speed = 2'd2;
        for (int i = 0; i < 16; i++) begin
            @(negedge enc_clk);
            in_valid = 1'b1; in_data = 16'($urandom);
        end
        @(negedge enc_clk);
        in_valid = 1'b0; enable = 1'b1;
        @(posedge enc_clk); #1;
        chk("os_data_start", 32'(sym_start), 32'd1);
        repeat (3) @(posedge enc_clk);
        @(negedge enc_clk);
        os_req = 1'b1; os_type = 4'd3; os_byte_0 = 8'hAA; os_byte_1 = 8'h55;
        @(negedge enc_clk);
        os_req = 1'b0;
`ifdef LANE_DIST_OS_EN
        found = 1'b0;
        for (t = 0; t < 20 && !found; t++) begin
            @(posedge enc_clk); #1;
            if (os_ack) found = 1'b1;
        end
        chk("os_ack_seen", 32'(found), 32'd1);
        chk("os_ack_wait", 32'(t), 32'd4);
        chk("os_dsel", 32'(d_sel), 32'd3);
        chk("os_lane0", 32'(lane_0_tx), 32'hAA);
        chk("os_lane1", 32'(lane_1_tx), 32'h55);
        chk("os_start", 32'(sym_start), 32'd1);
        repeat (7) @(posedge enc_clk);
        #1 chk("os_last_dsel", 32'(d_sel), 32'd3);
        @(posedge enc_clk); #1;
        chk("os_resume_dsel", 32'(d_sel), 32'd8);
        chk("os_resume_start", 32'(sym_start), 32'd1);
`else
        for (int i = 0; i < 20; i++) begin
            @(posedge enc_clk); #1;
            chk("no_os_ack", 32'(os_ack), 32'd0);
            chk("no_os_dsel", 32'(d_sel >= 4'd8), 32'd1);
        end
`endif

        // Drain, then fill to full with the framer held off.
        @(negedge enc_clk);
        gen_speed = 2'd0;
        repeat (40) @(negedge enc_clk);
        enable = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge enc_clk);
            in_valid = 1'b1; in_data = 16'($urandom);
            if (i == 0) first_beat = in_data;
        end
        @(negedge enc_clk);
        in_valid = 1'b0;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_level", 32'(fifo_level), 32'd32);
        enable = 1'b1;
        @(posedge enc_clk); #1;
        chk("full_pop_in_ready", 32'(in_ready), 32'd1);
        chk("full_pop_level", 32'(fifo_level), 32'd31);
        chk("full_pop_lane0", 32'(lane_0_tx), 32'(first_beat[7:0]));
        chk("full_pop_start", 32'(sym_start), 32'd1);
        repeat (40) @(negedge enc_clk);
        chk("full_drained", 32'(fifo_level), 32'd0);

        // Asynchronous reset in the middle of a data symbol.
        enable = 1'b0; gen_speed = 2'd2;
        for (int i = 0; i < 12; i++) begin
            @(negedge enc_clk);
            in_valid = 1'b1; in_data = 16'($urandom);
        end
        @(negedge enc_clk);
        in_valid = 1'b0; enable = 1'b1;
        @(posedge enc_clk);
        @(posedge enc_clk);
        @(posedge enc_clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_dsel", 32'(d_sel), 32'd9);
        chk("midrst_level", 32'(fifo_level), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_lane0", 32'(lane_0_tx), 32'd0);
        chk("midrst_start", 32'(sym_start), 32'd0);
        @(negedge enc_clk);
        rst = 1'b1;
        @(posedge enc_clk); #1;
        chk("midrst_next_dsel", 32'(d_sel), 32'd9);

        // Randomized traffic with alternating fill pressure.
        for (int c = 0; c < 3000; c++) begin
            @(negedge enc_clk);
            enable = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 39) == 0) gen_speed = 2'($urandom);
            in_valid = ($urandom_range(0, 9) < (((c / 400) % 2 == 1) ? 9 : 4));
            in_data = 16'($urandom);
            os_req = ($urandom_range(0, 29) == 0);
            os_type = 4'($urandom_range(0, 7));
            os_byte_0 = 8'($urandom);
            os_byte_1 = 8'($urandom);
        end
        @(negedge enc_clk);
        in_valid = 1'b0; os_req = 1'b0;
        repeat (4) @(negedge enc_clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
